// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file on the writeback side.
// One write port fed from MEM/WB and two combinational read ports for ID.
// x0 is hardwired to zero. a0 (x10) is exported for observation, and a
// counter tracks committed writes.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, the read
// ports forward data that is being written in the same cycle (write-first).
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic [ADDR_WIDTH-1:0] wb_reg_dest,
  input  logic                  wb_reg_write,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] a0,
  output logic [CNT_WIDTH-1:0]  wr_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A0_IDX = ADDR_WIDTH'(10);

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  commit;

  // A write only commits when it is enabled and does not target x0.
  assign commit = wb_reg_write && (wb_reg_dest != '0);

  // Register array. Reset clears every entry, and x0 is never written afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wb_reg_dest] <= wb_data;
    end
  end

  // Counts committed writes. The count wraps silently when it overflows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_count <= '0;
    else if (commit) wr_count <= wr_count + CNT_WIDTH'(1);
  end

  // Read port 1. It returns zero for x0 and while reset is held.
  always_comb begin
    rs1_data = '0;
    if (rst_n && (rs1_addr != '0)) begin
      rs1_data = regs[rs1_addr];
`ifdef REGFILE_BYPASS_EN
      if (commit && (wb_reg_dest == rs1_addr)) rs1_data = wb_data;
`endif
    end
  end

  // Read port 2. It behaves the same way as port 1.
  always_comb begin
    rs2_data = '0;
    if (rst_n && (rs2_addr != '0)) begin
      rs2_data = regs[rs2_addr];
`ifdef REGFILE_BYPASS_EN
      if (commit && (wb_reg_dest == rs2_addr)) rs2_data = wb_data;
`endif
    end
  end

  // a0 shows the registered contents only. It is never bypassed.
  assign a0 = regs[A0_IDX];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile. The counter width is set to 4
// so that the wrap case can be reached in a few writes.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg_dest;
  logic        wb_reg_write;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] a0;
  logic [3:0]  wr_count;

  int tests = 0;
  int fails = 0;

  wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wb_data(wb_data), .wb_reg_dest(wb_reg_dest),
    .wb_reg_write(wb_reg_write), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .a0(a0), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] dest, input logic [31:0] data);
    wb_reg_write = 1'b1;
    wb_reg_dest  = dest;
    wb_data      = data;
    tick();
    wb_reg_write = 1'b0;
  endtask

  logic [31:0] hazard_exp;

  initial begin
    rst_n = 1'b0; wb_data = '0; wb_reg_dest = '0; wb_reg_write = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    tick();
    check("reset_cnt", {28'd0, wr_count}, 32'd0);
    check("reset_a0", a0, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: asynchronous reset in the middle of a run
    wr(5'd5, 32'h0000_1234);
    wr(5'd10, 32'h0000_0077);
    rs1_addr = 5'd5;
    #1;
    check("t1_pre_x5", rs1_data, 32'h0000_1234);
    check("t1_pre_cnt", {28'd0, wr_count}, 32'd2);
    wb_reg_write = 1'b1; wb_reg_dest = 5'd5; wb_data = 32'h0000_9999;
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_x5", rs1_data, 32'd0);
    check("t1_async_a0", a0, 32'd0);
    check("t1_async_cnt", {28'd0, wr_count}, 32'd0);
    tick();
    check("t1_inrst_x5", rs1_data, 32'd0);
    check("t1_inrst_cnt", {28'd0, wr_count}, 32'd0);
    wb_reg_write = 1'b0;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      check($sformatf("t1_clear_rs1_x%0d", i), rs1_data, 32'd0);
      check($sformatf("t1_clear_rs2_x%0d", 31 - i), rs2_data, 32'd0);
    end

    // 2: basic write to x10
    rs2_addr = 5'd10;
    wr(5'd10, 32'hDEAD_BEEF);
    check("t2_a0", a0, 32'hDEAD_BEEF);
    check("t2_rs2", rs2_data, 32'hDEAD_BEEF);
    check("t2_cnt", {28'd0, wr_count}, 32'd1);

    // 3: a write to x0 is discarded
    rs1_addr = 5'd0;
    wr(5'd0, 32'hFFFF_FFFF);
    check("t3_x0", rs1_data, 32'd0);
    check("t3_cnt", {28'd0, wr_count}, 32'd1);

    // 4: a disabled write changes nothing
    wr(5'd7, 32'h0000_0011);
    wb_reg_write = 1'b0; wb_reg_dest = 5'd7; wb_data = 32'h0000_0055;
    tick();
    rs1_addr = 5'd7;
    #1;
    check("t4_x7", rs1_data, 32'h0000_0011);
    check("t4_cnt", {28'd0, wr_count}, 32'd2);

    // 5: read of a register in the same cycle it is written
    wr(5'd3, 32'h0000_000A);
    rs1_addr = 5'd3; rs2_addr = 5'd3;
    wb_reg_write = 1'b1; wb_reg_dest = 5'd3; wb_data = 32'h0000_000B;
`ifdef REGFILE_BYPASS_EN
    hazard_exp = 32'h0000_000B;
`else
    hazard_exp = 32'h0000_000A;
`endif
    #1;
    check("t5_same_rs1", rs1_data, hazard_exp);
    check("t5_same_rs2", rs2_data, hazard_exp);
    tick();
    wb_reg_write = 1'b0;
    #1;
    check("t5_next_rs1", rs1_data, 32'h0000_000B);
    check("t5_cnt", {28'd0, wr_count}, 32'd4);
    rs1_addr = 5'd0;
    wb_reg_write = 1'b1; wb_reg_dest = 5'd0; wb_data = 32'h1234_5678;
    #1;
    check("t5_x0_nobypass", rs1_data, 32'd0);
    wb_reg_write = 1'b0;
    rs1_addr = 5'd10;
    wb_reg_write = 1'b1; wb_reg_dest = 5'd10; wb_data = 32'hCAFE_0000;
    #1;
    check("t5_a0_nobypass", a0, 32'hDEAD_BEEF);
    wb_reg_write = 1'b0;
    #1;

    // 6: counter wraps, then back-to-back writes to one register
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 17; i++) wr(5'(i), 32'(i * 16 + 1));
    check("t6_wrap_cnt", {28'd0, wr_count}, 32'd1);
    rs1_addr = 5'd17; rs2_addr = 5'd1;
    #1;
    check("t6_x17", rs1_data, 32'd273);
    check("t6_x1", rs2_data, 32'd17);
    wb_reg_write = 1'b1; wb_reg_dest = 5'd4; wb_data = 32'd1;
    tick();
    wb_data = 32'd2;
    tick();
    wb_reg_write = 1'b0;
    rs1_addr = 5'd4;
    #1;
    check("t6_b2b_x4", rs1_data, 32'd2);
    check("t6_b2b_cnt", {28'd0, wr_count}, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
